// File: rtl/nrisc_regfile_if.sv
// Write and read bus of the nRISC register file: write-back port plus two read ports.
// Latency: none (wires only).
// Backpressure: none; the register file accepts one write every cycle.
interface nrisc_regfile_if #(
    parameter int W  = 8,
    parameter int AW = 2
);
    logic          RegWrite;
    logic [AW-1:0] wAddr;
    logic [W-1:0]  wData;
    logic [AW-1:0] rAddrA;
    logic [AW-1:0] rAddrB;
    logic [W-1:0]  rDataA;
    logic [W-1:0]  rDataB;

    // Control unit / write-back mux side.
    modport master (
        output RegWrite, wAddr, wData, rAddrA, rAddrB,
        input  rDataA, rDataB
    );

    // Register file side.
    modport slave (
        input  RegWrite, wAddr, wData, rAddrA, rAddrB,
        output rDataA, rDataB
    );
endinterface

// File: rtl/nrisc_regfile.sv
// 2^AW x W register file for the nRISC datapath; optional r0 hardwired to zero.
// Latency: write lands 1 edge later, reads are combinational (0 cycles).
// Backpressure: none; a write can be taken every cycle.
// Optional feature: define NRISC_REGFILE_BYPASS_EN to forward wData to a read port
// addressing the register being written in the same cycle.
module nrisc_regfile #(
    parameter int W        = 8,
    parameter int AW       = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    nrisc_regfile_if.slave  rf
);
    localparam int N = 1 << AW;

    logic [W-1:0] regs [N];

    // A write to r0 is dropped when r0 is the hardwired zero register.
    logic wrDiscard;
    logic wrEn;

    assign wrDiscard = ZERO_REG && (rf.wAddr == '0);
    assign wrEn      = rf.RegWrite && !wrDiscard;

    // Storage: async clear on reset, single write port on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn) begin
            regs[rf.wAddr] <= rf.wData;
        end
    end

    // Read port A: stored value, zero for r0 when hardwired, zero while in reset.
    always_comb begin
        rf.rDataA = '0;
        if (rst_n && !(ZERO_REG && (rf.rAddrA == '0))) begin
            rf.rDataA = regs[rf.rAddrA];
        end
`ifdef NRISC_REGFILE_BYPASS_EN
        // Same-cycle forwarding; wrEn already excludes discarded r0 writes.
        if (rst_n && wrEn && (rf.rAddrA == rf.wAddr)) begin
            rf.rDataA = rf.wData;
        end
`endif
    end

    // Read port B: identical rules, independent address.
    always_comb begin
        rf.rDataB = '0;
        if (rst_n && !(ZERO_REG && (rf.rAddrB == '0))) begin
            rf.rDataB = regs[rf.rAddrB];
        end
`ifdef NRISC_REGFILE_BYPASS_EN
        if (rst_n && wrEn && (rf.rAddrB == rf.wAddr)) begin
            rf.rDataB = rf.wData;
        end
`endif
    end
endmodule

// File: doc/nrisc_regfile.md
# nrisc_regfile

Register file for the 8-bit nRISC datapath, sitting directly downstream of the write-back select multiplexer (memory read data vs. ALU result, steered by `MemtoREG`). It stores the selected write-back value into the addressed register on the clock edge and supplies two combinational read ports to the ALU and operand-select logic. An optional same-cycle write-to-read bypass can be compiled in.

## Interface
Parameters:
- `W`, 8, data width in bits.
- `AW`, 2, register address width; register count is 2^AW.
- `ZERO_REG`, 1, when 1, register 0 reads as 0 and ignores writes; when 0, register 0 is an ordinary register.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `RegWrite`  in  1  write enable from control unit.
- `wAddr`  in  AW  destination register address.
- `wData`  in  W  write-back value, driven by the write-back mux output.
- `rAddrA`  in  AW  read port A address.
- `rAddrB`  in  AW  read port B address.
- `rDataA`  out  W  read port A data.
- `rDataB`  out  W  read port B data.

## Operation
- Storage: 2^AW registers of W bits, `regs[0..2^AW-1]`.
- Reset: `rst_n` low clears every register to 0 immediately, without waiting for a clock edge. While `rst_n` is low, `rDataA` = `rDataB` = 0 and writes are ignored.
- Write: on a rising `clk` edge with `rst_n` high and `RegWrite` = 1, `regs[wAddr]` <= `wData`. If `ZERO_REG` = 1 and `wAddr` = 0, the write is discarded.
- `RegWrite` = 0: no register changes; `wAddr` and `wData` are don't-care.
- Read: `rDataX` = `regs[rAddrX]`, purely combinational. If `ZERO_REG` = 1 and `rAddrX` = 0, `rDataX` = 0.
- Both read ports are independent. Same address on A and B returns the same value.
- No arithmetic is performed; `wData` is stored unmodified at full width W.
- X/Z on `wAddr` while `RegWrite` = 1 is illegal stimulus. The bench flags it; the RTL makes no guarantee.

## Timing
- Write latency: 1 edge. Data written at edge N is visible on the read ports after edge N, with bypass disabled.
- Read latency: 0 cycles (combinational from `rAddrX` and register state).
- Reset assertion mid-cycle: the registers and both outputs go to 0 asynchronously in the same delta. A write edge coincident with `rst_n` low is lost.
- Reset release: the first write takes effect on the first rising edge at which `rst_n` is high.
- Simultaneous read and write of the same address:
  - With bypass disabled, the read returns the old value until the edge.
  - With bypass enabled, see Configuration.
- No handshake. The block accepts a write every cycle; back-to-back writes to the same address keep the last value.

## Configuration
- Macro: `NRISC_REGFILE_BYPASS_EN`.
- Defined:
  - When `rst_n` = 1, `RegWrite` = 1, `rAddrX` = `wAddr`, and the write is not discarded by `ZERO_REG`, `rDataX` = `wData` combinationally in the same cycle.
  - The bypass applies independently to A and B.
  - Register state update is unchanged.
- Undefined: there is no bypass path. Reads always return stored register contents; same-cycle write/read returns the pre-write value.

## Test plan
- Reset: load all regs with 0xFF, pulse `rst_n` low between edges -> all reads = 0x00 immediately, before the next edge.
- Basic write/read: write 0x11 to r1 and 0x0D to r2 on consecutive edges, then `rAddrA`=1, `rAddrB`=2 -> `rDataA`=0x11, `rDataB`=0x0D.
- Zero register (`ZERO_REG`=1): write 0xAA to r0 -> `rDataA` with `rAddrA`=0 stays 0x00. With `ZERO_REG`=0, the same write reads back 0xAA.
- Write enable: `RegWrite`=0, `wAddr`=3, `wData`=0x55 over 3 edges -> r3 keeps its prior value of 0x00.
- Same-cycle hazard: r1=0x11, drive `RegWrite`=1, `wAddr`=1, `wData`=0x22, `rAddrA`=1 before the edge:
  - Without `NRISC_REGFILE_BYPASS_EN` -> 0x11 before the edge, 0x22 after.
  - With the macro defined -> 0x22 before the edge.
- Reset vs. write race: `rst_n` low across an edge with `RegWrite`=1, `wData`=0x7E -> register remains 0x00 after release.
